// File: rtl/vproc_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface : vproc_mem_bridge_if
// Purpose   : Bundles the vproc-side memory port and the req/gnt/rvalid
//             backend port of vproc_mem_bridge.
// Modports  : slave  - the bridge (takes vproc requests, drives backend req)
//             master - the surrounding system (vproc core + backend memory)
// Signals   : vproc_mem_req/addr/we/be/wdata   core -> bridge
//             vproc_mem_rvalid/err/rdata       bridge -> core
//             ds_req/addr/we/be/wdata          bridge -> backend
//             ds_gnt/rvalid/err/rdata          backend -> bridge
// Revision  : 1.0 - initial release
// ============================================================================
interface vproc_mem_bridge_if #(
  parameter int MEM_W = 32
);
  logic                 vproc_mem_req_i;
  logic [31:0]          vproc_mem_addr_i;
  logic                 vproc_mem_we_i;
  logic [MEM_W/8-1:0]   vproc_mem_be_i;
  logic [MEM_W-1:0]     vproc_mem_wdata_i;
  logic                 vproc_mem_rvalid_o;
  logic                 vproc_mem_err_o;
  logic [MEM_W-1:0]     vproc_mem_rdata_o;

  logic                 ds_req_o;
  logic [31:0]          ds_addr_o;
  logic                 ds_we_o;
  logic [MEM_W/8-1:0]   ds_be_o;
  logic [MEM_W-1:0]     ds_wdata_o;
  logic                 ds_gnt_i;
  logic                 ds_rvalid_i;
  logic                 ds_err_i;
  logic [MEM_W-1:0]     ds_rdata_i;

  modport slave (
    input  vproc_mem_req_i, vproc_mem_addr_i, vproc_mem_we_i,
           vproc_mem_be_i, vproc_mem_wdata_i,
    output vproc_mem_rvalid_o, vproc_mem_err_o, vproc_mem_rdata_o,
    output ds_req_o, ds_addr_o, ds_we_o, ds_be_o, ds_wdata_o,
    input  ds_gnt_i, ds_rvalid_i, ds_err_i, ds_rdata_i
  );

  modport master (
    output vproc_mem_req_i, vproc_mem_addr_i, vproc_mem_we_i,
           vproc_mem_be_i, vproc_mem_wdata_i,
    input  vproc_mem_rvalid_o, vproc_mem_err_o, vproc_mem_rdata_o,
    input  ds_req_o, ds_addr_o, ds_we_o, ds_be_o, ds_wdata_o,
    output ds_gnt_i, ds_rvalid_i, ds_err_i, ds_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/vproc_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module    : vproc_mem_bridge
// Purpose   : Accepts vproc_top memory requests unconditionally (no grant),
//             queues them in an in-order FIFO and replays them one at a time
//             to a req/gnt/rvalid backend. Responses return in issue order.
// Ports     : clk, rst (async, active-high)
//             bus        vproc_mem_bridge_if.slave (vproc side + backend side)
//             level_o    FIFO occupancy
//             overflow_o sticky flag: a request was dropped because the FIFO
//                        was full with no pop in the same cycle
// Options   : MEM_BRIDGE_ADDR_CHECK_EN - when defined, requests outside
//             [ADDR_LO, ADDR_HI) are answered with err=1 and never reach the
//             backend. When undefined every request is forwarded.
// Revision  : 1.0 - initial release
// ============================================================================
module vproc_mem_bridge #(
  parameter int          MEM_W   = 32,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] ADDR_LO = 32'h0000_2000,
  parameter logic [31:0] ADDR_HI = 32'h0004_2000
) (
  input  logic                       clk,
  input  logic                       rst,
  vproc_mem_bridge_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
);

  localparam int BE_W  = MEM_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Request storage (data path only, no reset needed)
  // --------------------------------------------------------------------------
  logic [31:0]       addr_mem  [DEPTH];
  logic              we_mem    [DEPTH];
  logic [BE_W-1:0]   be_mem    [DEPTH];
  logic [MEM_W-1:0]  wdata_mem [DEPTH];
  logic              bad_mem   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  state_t            state;

  logic              ds_req_q;
  logic [31:0]       ds_addr_q;
  logic              ds_we_q;
  logic [BE_W-1:0]   ds_be_q;
  logic [MEM_W-1:0]  ds_wdata_q;
  logic              rvalid_q;
  logic              err_q;
  logic [MEM_W-1:0]  rdata_q;

  logic              in_bad;
  logic              empty;
  logic              full;
  logic              pop_wait;
  logic              pop_bad;
  logic              pop;
  logic              push;
  logic              launch;

  logic [31:0]       head_addr;
  logic              head_we;
  logic [BE_W-1:0]   head_be;
  logic [MEM_W-1:0]  head_wdata;
  logic              head_bad;

  logic [31:0]       cand_addr;
  logic              cand_we;
  logic [BE_W-1:0]   cand_be;
  logic [MEM_W-1:0]  cand_wdata;

  // --------------------------------------------------------------------------
  // Address legality
  // --------------------------------------------------------------------------
`ifdef MEM_BRIDGE_ADDR_CHECK_EN
  assign in_bad = (bus.vproc_mem_addr_i < ADDR_LO) ||
                  (bus.vproc_mem_addr_i >= ADDR_HI);
`else
  logic unused_addr_bounds;
  assign unused_addr_bounds = ^{ADDR_LO, ADDR_HI};
  assign in_bad             = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FIFO flags and handshakes
  // --------------------------------------------------------------------------
  assign empty      = (level_o == '0);
  assign full       = (level_o == LVL_FULL);

  assign head_addr  = addr_mem[rd_ptr];
  assign head_we    = we_mem[rd_ptr];
  assign head_be    = be_mem[rd_ptr];
  assign head_wdata = wdata_mem[rd_ptr];
  assign head_bad   = bad_mem[rd_ptr];

  // A bad head is retired straight from IDLE without touching the backend.
  assign pop_wait = (state == S_WAIT) && bus.ds_rvalid_i;
  assign pop_bad  = (state == S_IDLE) && !empty && head_bad;
  assign pop      = pop_wait || pop_bad;

  // Fullness is judged after the same-cycle pop, so a full FIFO that is
  // draining this cycle still accepts the incoming request.
  assign push = bus.vproc_mem_req_i && (!full || pop);

  // When the FIFO is empty the request being pushed this cycle becomes the
  // head, so IDLE launches it directly; this gives ds_req_o one cycle after
  // the vproc request instead of two.
  assign cand_addr  = empty ? bus.vproc_mem_addr_i  : head_addr;
  assign cand_we    = empty ? bus.vproc_mem_we_i    : head_we;
  assign cand_be    = empty ? bus.vproc_mem_be_i    : head_be;
  assign cand_wdata = empty ? bus.vproc_mem_wdata_i : head_wdata;

  assign launch = (state == S_IDLE) &&
                  (empty ? (bus.vproc_mem_req_i && !in_bad) : !head_bad);

  // --------------------------------------------------------------------------
  // Storage write
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin : storage_wr
    if (push) begin
      addr_mem[wr_ptr]  <= bus.vproc_mem_addr_i;
      we_mem[wr_ptr]    <= bus.vproc_mem_we_i;
      be_mem[wr_ptr]    <= bus.vproc_mem_be_i;
      wdata_mem[wr_ptr] <= bus.vproc_mem_wdata_i;
      bad_mem[wr_ptr]   <= in_bad;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin : fifo_ctrl
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_o <= level_o + LVL_ONE;
        2'b01:   level_o <= level_o - LVL_ONE;
        default: level_o <= level_o;
      endcase
      if (bus.vproc_mem_req_i && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Backend sequencer and response register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin : fsm
    if (rst) begin
      state      <= S_IDLE;
      ds_req_q   <= 1'b0;
      ds_addr_q  <= '0;
      ds_we_q    <= 1'b0;
      ds_be_q    <= '0;
      ds_wdata_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // One-cycle response per pop; data/err forced to 0 otherwise.
      rvalid_q <= pop;
      err_q    <= pop_bad || (pop_wait && bus.ds_err_i);
      rdata_q  <= (pop_wait && !head_we && !bus.ds_err_i) ? bus.ds_rdata_i : '0;

      case (state)
        S_IDLE: begin
          if (launch) begin
            state      <= S_REQ;
            ds_req_q   <= 1'b1;
            ds_addr_q  <= cand_addr;
            ds_we_q    <= cand_we;
            ds_be_q    <= cand_be;
            ds_wdata_q <= cand_wdata;
          end
        end
        S_REQ: begin
          // Request fields stay frozen in ds_*_q until the grant.
          if (bus.ds_gnt_i) begin
            state    <= S_WAIT;
            ds_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.ds_rvalid_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          ds_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ds_req_o           = ds_req_q;
  assign bus.ds_addr_o          = ds_addr_q;
  assign bus.ds_we_o            = ds_we_q;
  assign bus.ds_be_o            = ds_be_q;
  assign bus.ds_wdata_o         = ds_wdata_q;
  assign bus.vproc_mem_rvalid_o = rvalid_q;
  assign bus.vproc_mem_err_o    = err_q;
  assign bus.vproc_mem_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vproc_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module    : tb_vproc_mem_bridge
// Purpose   : Self-checking bench for vproc_mem_bridge. Directed requests push
//             their expected responses into a queue; a monitor pops and
//             compares on every vproc rvalid. A behavioural backend answers
//             ds_req with configurable grant blocking and response delay.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_vproc_mem_bridge;

  logic        clk;
  logic        rst;
  logic [2:0]  level;
  logic        overflow;

  vproc_mem_bridge_if #(.MEM_W(32)) bus ();

  vproc_mem_bridge #(
    .MEM_W  (32),
    .DEPTH  (4),
    .ADDR_LO(32'h0000_2000),
    .ADDR_HI(32'h0004_2000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .level_o   (level),
    .overflow_o(overflow)
  );

  int          tests;
  int          failed;
  int          cyc;
  int          resp_count;
  int          t0;
  logic [32:0] exp_q [$];        // {err, rdata}
  logic [31:0] seen_addr [$];
  int          req_cycles [$];
  int          rv_cycles [$];
  int          resp_cycles [$];
  logic        gnt_block;
  int          rv_delay;
  logic [31:0] bk_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h0000_2000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // --------------------------------------------------------------------------
  // Backend: grant on the first unblocked ds_req, respond rv_delay cycles
  // after the grant is dropped. Address 0x2020 is answered with an error.
  // --------------------------------------------------------------------------
  initial begin
    bus.ds_gnt_i    = 1'b0;
    bus.ds_rvalid_i = 1'b0;
    bus.ds_err_i    = 1'b0;
    bus.ds_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (bus.ds_req_o && !gnt_block && !rst) begin
        bk_addr = bus.ds_addr_o;
        seen_addr.push_back(bk_addr);
        req_cycles.push_back(cyc);
        bus.ds_gnt_i = 1'b1;
        @(negedge clk);
        bus.ds_gnt_i = 1'b0;
        repeat (rv_delay) @(negedge clk);
        bus.ds_rvalid_i = 1'b1;
        bus.ds_rdata_i  = rd_model(bk_addr);
        bus.ds_err_i    = (bk_addr == 32'h0000_2020);
        rv_cycles.push_back(cyc);
        @(negedge clk);
        bus.ds_rvalid_i = 1'b0;
        bus.ds_rdata_i  = '0;
        bus.ds_err_i    = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (bus.vproc_mem_rvalid_o) begin
        resp_count++;
        resp_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_resp: got rvalid with err=%0b rdata=%0h required no response",
                   bus.vproc_mem_err_o, bus.vproc_mem_rdata_o);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", 64'(bus.vproc_mem_err_o), 64'(e[32]));
          check("resp_rdata", 64'(bus.vproc_mem_rdata_o), 64'(e[31:0]));
        end
      end else begin
        check("idle_resp_zero", 64'({bus.vproc_mem_err_o, bus.vproc_mem_rdata_o}), 64'd0);
      end
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bus.vproc_mem_req_i   = 1'b1;
    bus.vproc_mem_addr_i  = a;
    bus.vproc_mem_we_i    = we;
    bus.vproc_mem_be_i    = 4'hF;
    bus.vproc_mem_wdata_i = wd;
  endtask

  task automatic idle_req();
    bus.vproc_mem_req_i   = 1'b0;
    bus.vproc_mem_addr_i  = '0;
    bus.vproc_mem_we_i    = 1'b0;
    bus.vproc_mem_be_i    = '0;
    bus.vproc_mem_wdata_i = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 200), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    seen_addr.delete();
    req_cycles.delete();
    rv_cycles.delete();
    resp_cycles.delete();
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int rc;
    logic hit;
    tests = 0; failed = 0; resp_count = 0; t0 = 0;
    gnt_block = 1'b0;
    rv_delay  = 2;
    rst = 1'b1;
    idle_req();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rvalid", 64'(bus.vproc_mem_rvalid_o), 64'd0);
    check("rst_ds_req", 64'(bus.ds_req_o), 64'd0);
    check("rst_ds_addr", 64'(bus.ds_addr_o), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single read 0x2000, grant immediately, rvalid at cycle 4
    clear_logs();
    rv_delay = 2;
    @(negedge clk);
    t0 = cyc;
    drive_req(32'h0000_2000, 1'b0, 32'h0);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    idle_req();
    wait_idle("t1_drain");
    check("t1_req_count", 64'(req_cycles.size()), 64'd1);
    if (req_cycles.size() >= 1) check("t1_req_latency", 64'(req_cycles[0] - t0), 64'd1);
    check("t1_resp_count", 64'(resp_cycles.size()), 64'd1);
    if (resp_cycles.size() >= 1) check("t1_resp_latency", 64'(resp_cycles[0] - t0), 64'd5);

    // 2: four writes with grant held low, FIFO fills to 4
    clear_logs();
    gnt_block = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(32'h0000_2100 + 32'(4 * i), 1'b1, 32'h1111_0000 + 32'(i));
      exp_q.push_back({1'b0, 32'h0});
    end
    @(negedge clk);
    idle_req();
    check("t2_level_full", 64'(level), 64'd4);
    check("t2_ds_req", 64'(bus.ds_req_o), 64'd1);
    check("t2_ds_addr", 64'(bus.ds_addr_o), 64'h2100);
    check("t2_ds_we", 64'(bus.ds_we_o), 64'd1);
    check("t2_ds_wdata", 64'(bus.ds_wdata_o), 64'h1111_0000);
    repeat (10) @(negedge clk);
    check("t2_ds_req_held", 64'(bus.ds_req_o), 64'd1);
    check("t2_ds_addr_held", 64'(bus.ds_addr_o), 64'h2100);
    check("t2_overflow_clear", 64'(overflow), 64'd0);

    // 3: fifth request while full with no pop is dropped
    @(negedge clk);
    drive_req(32'h0000_2200, 1'b1, 32'h2222_2222);
    @(negedge clk);
    idle_req();
    check("t3_overflow_set", 64'(overflow), 64'd1);
    check("t3_level", 64'(level), 64'd4);
    gnt_block = 1'b0;
    wait_idle("t3_drain");
    check("t3_overflow_sticky", 64'(overflow), 64'd1);
    check("t3_ds_count", 64'(seen_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen_addr.size())
        check("t3_ds_addr_order", 64'(seen_addr[i]), 64'h2100 + 64'(4 * i));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t3_overflow_rst", 64'(overflow), 64'd0);
    check("t3_level_rst", 64'(level), 64'd0);

    // 4: push while full in the same cycle as a pop
    clear_logs();
    gnt_block = 1'b1;
    rv_delay  = 1;
    @(negedge clk);
    drive_req(32'h0000_2300, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_2300});
    @(negedge clk);
    drive_req(32'h0000_2304, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_2304});
    @(negedge clk);
    drive_req(32'h0000_2308, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_2308});
    @(negedge clk);
    drive_req(32'h0000_230C, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_230C});
    @(negedge clk);
    idle_req();
    check("t4_level_full", 64'(level), 64'd4);
    gnt_block = 1'b0;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      @(negedge clk);
      #1;
      if (bus.ds_rvalid_i) begin
        hit = 1'b1;
        drive_req(32'h0000_2310, 1'b0, 32'h0);
        exp_q.push_back({1'b0, 32'h5A5A_2310});
      end
      n++;
    end
    check("t4_pop_seen", 64'(hit), 64'd1);
    @(negedge clk);
    idle_req();
    check("t4_level_same", 64'(level), 64'd4);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    wait_idle("t4_drain");
    check("t4_ds_count", 64'(seen_addr.size()), 64'd5);

    // 5: reset during WAIT, late backend response must be ignored
    clear_logs();
    rv_delay = 4;
    @(negedge clk);
    drive_req(32'h0000_2400, 1'b0, 32'h0);
    @(negedge clk);
    idle_req();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rc = resp_count;
    repeat (8) @(negedge clk);
    check("t5_no_resp", 64'(resp_count), 64'(rc));
    check("t5_level", 64'(level), 64'd0);
    check("t5_ds_req_idle", 64'(bus.ds_req_o), 64'd0);
    rv_delay = 1;
    @(negedge clk);
    drive_req(32'h0000_2008, 1'b0, 32'h0);
    exp_q.push_back({1'b0, 32'h5A5A_2008});
    @(negedge clk);
    idle_req();
    wait_idle("t5_recover");

    // 6: zero-wait backend, back-to-back reads, backend error
    clear_logs();
    rv_delay = 0;
    @(negedge clk);
    t0 = cyc;
    drive_req(32'h0000_2010, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_2010});
    @(negedge clk);
    drive_req(32'h0000_2014, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_2014});
    @(negedge clk);
    drive_req(32'h0000_2020, 1'b0, 32'h0); exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    idle_req();
    wait_idle("t6_drain");
    check("t6_resp_count", 64'(resp_cycles.size()), 64'd3);
    if (resp_cycles.size() >= 1) check("t6_min_latency", 64'(resp_cycles[0] - t0), 64'd3);
    check("t6_req_count", 64'(req_cycles.size()), 64'd3);
    if (req_cycles.size() >= 2 && rv_cycles.size() >= 1)
      check("t6_b2b_gap", 64'(req_cycles[1] - rv_cycles[0]), 64'd2);

    // 7: out-of-range address between two legal reads
    clear_logs();
    @(negedge clk);
    drive_req(32'h0000_2000, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
`ifdef MEM_BRIDGE_ADDR_CHECK_EN
    drive_req(32'h0000_1FFC, 1'b0, 32'h0); exp_q.push_back({1'b1, 32'h0});
`else
    drive_req(32'h0000_1FFC, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_1FFC});
`endif
    @(negedge clk);
    drive_req(32'h0000_2004, 1'b0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A_2004});
    @(negedge clk);
    idle_req();
    wait_idle("t7_drain");
    check("t7_resp_count", 64'(resp_cycles.size()), 64'd3);
`ifdef MEM_BRIDGE_ADDR_CHECK_EN
    check("t7_ds_count", 64'(seen_addr.size()), 64'd2);
    if (seen_addr.size() >= 2) check("t7_ds_addr1", 64'(seen_addr[1]), 64'h2004);
`else
    check("t7_ds_count", 64'(seen_addr.size()), 64'd3);
    if (seen_addr.size() >= 2) check("t7_ds_addr1", 64'(seen_addr[1]), 64'h1FFC);
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
